// File: rtl/my_struct_package.sv
// my_struct_package: shared types and opcodes for the L1 cache command sequencer
package my_struct_package;
  typedef enum logic [2:0] {IDLE, READ_SET, LOOKUP, BUS_REQ, BUS_WAIT, WRITE_SET, CLEAR} seq_state_t;
  typedef enum logic [1:0] {L2_READ = 2'd0, L2_WRITE = 2'd1, L2_RFO = 2'd2, L2_INVAL = 2'd3} l2_op_t;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] addr;
  } command_t;
  localparam logic [3:0] OP_DREAD    = 4'd0;
  localparam logic [3:0] OP_DWRITE   = 4'd1;
  localparam logic [3:0] OP_IFETCH   = 4'd2;
  localparam logic [3:0] OP_L2_INVAL = 4'd3;
  localparam logic [3:0] OP_L2_SNOOP = 4'd4;
  localparam logic [3:0] OP_CLEAR    = 4'd8;
  localparam logic [3:0] OP_PRINT    = 4'd9;
endpackage

// File: rtl/cache_stats_counter.sv
// cache_stats_counter: 32-bit saturating event counter with synchronous clear
module cache_stats_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/cache_cmd_sequencer.sv
// cache_cmd_sequencer: per-command set read/lookup/L2 bus/write-back sequencing and clear sweep.
// Define CACHE_STATS_EN to build the hit/miss/read/write statistics counters.
module cache_cmd_sequencer
  import my_struct_package::*;
#(
  parameter int SET_BITS    = 14,
  parameter int OFFSET_BITS = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  command_t                            cmd,
  output logic [SET_BITS-1:0]                 set_index,
  output logic                                rd_en,
  output logic                                wr_en,
  output logic                                clear_en,
  input  logic                                dp_hit,
  input  logic                                dp_victim_mod,
  input  logic                                dp_victim_shared,
  input  logic [31-SET_BITS-OFFSET_BITS:0]    dp_victim_tag,
  output logic                                l2_req_valid,
  output l2_op_t                              l2_req_op,
  output logic [31:0]                         l2_req_addr,
  input  logic                                l2_req_ready,
  input  logic                                l2_done,
  output logic                                print_req,
  output logic                                busy,
  output logic [31:0]                         hit_cnt,
  output logic [31:0]                         miss_cnt,
  output logic [31:0]                         read_cnt,
  output logic [31:0]                         write_cnt
);
  localparam int TB = 32 - SET_BITS - OFFSET_BITS;
  seq_state_t r_state, w_next;
  logic [3:0] r_op;
  logic [TB-1:0] r_tag;
  logic [SET_BITS-1:0] r_set, r_clr_idx;
  l2_op_t r_q_op [2];
  logic [31:0] r_q_addr [2];
  logic [1:0] r_q_n, w_n;
  l2_op_t w_op0, w_op1, w_fill_op;
  logic [31:0] w_a0, w_a1, w_line, w_wb;
  logic r_print, w_accept, w_fill, w_unused;
  assign cmd_ready = r_state == IDLE && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_line    = {r_tag, r_set, {OFFSET_BITS{1'b0}}};
  assign w_wb      = {dp_victim_tag, r_set, {OFFSET_BITS{1'b0}}};
  assign w_fill    = !dp_hit && r_op <= OP_IFETCH;
  assign w_fill_op = r_op == OP_DWRITE ? L2_RFO : L2_READ;
  assign w_unused  = ^cmd.addr[OFFSET_BITS-1:0];
  // Bus plan: optional victim write-back always precedes the fill
  always_comb begin
    w_n = 2'd0;
    w_op0 = L2_READ;
    w_a0 = w_line;
    w_op1 = w_fill_op;
    w_a1 = w_line;
    if (w_fill) begin
      w_n = dp_victim_mod ? 2'd2 : 2'd1;
      w_op0 = dp_victim_mod ? L2_WRITE : w_fill_op;
      w_a0 = dp_victim_mod ? w_wb : w_line;
    end else if (dp_hit && r_op == OP_DWRITE && dp_victim_shared) begin
      w_n = 2'd1;
      w_op0 = L2_INVAL;
    end else if (dp_hit && r_op == OP_L2_SNOOP && dp_victim_mod) begin
      w_n = 2'd1;
      w_op0 = L2_WRITE;
      w_a0 = w_wb;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = cmd.opcode <= OP_L2_SNOOP ? READ_SET :
                                        cmd.opcode == OP_CLEAR ? CLEAR : IDLE;
      READ_SET:  w_next = LOOKUP;
      LOOKUP:    w_next = w_n == 2'd0 ? WRITE_SET : BUS_REQ;
      BUS_REQ:   if (l2_req_ready) w_next = BUS_WAIT;
      BUS_WAIT:  if (l2_done) w_next = r_q_n > 2'd1 ? BUS_REQ : WRITE_SET;
      WRITE_SET: w_next = IDLE;
      CLEAR:     if (r_clr_idx == '1) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_tag     <= '0;
      r_set     <= '0;
      r_clr_idx <= '0;
      r_q_n     <= '0;
      r_q_op    <= '{L2_READ, L2_READ};
      r_q_addr  <= '{32'd0, 32'd0};
      r_print   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_print <= w_accept && cmd.opcode == OP_PRINT;
      if (w_accept) begin
        r_op      <= cmd.opcode;
        r_tag     <= cmd.addr[31 -: TB];
        r_set     <= cmd.addr[OFFSET_BITS +: SET_BITS];
        r_clr_idx <= '0;
      end
      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + SET_BITS'(1);
      if (r_state == LOOKUP) begin
        r_q_n       <= w_n;
        r_q_op[0]   <= w_op0;
        r_q_op[1]   <= w_op1;
        r_q_addr[0] <= w_a0;
        r_q_addr[1] <= w_a1;
      end else if (r_state == BUS_WAIT && l2_done) begin
        r_q_n       <= r_q_n - 2'd1;
        r_q_op[0]   <= r_q_op[1];
        r_q_addr[0] <= r_q_addr[1];
      end
    end
  end
  assign rd_en        = r_state == READ_SET;
  assign wr_en        = r_state == WRITE_SET || r_state == CLEAR;
  assign clear_en     = r_state == CLEAR;
  assign set_index    = r_state == CLEAR ? r_clr_idx : r_set;
  assign l2_req_valid = r_state == BUS_REQ;
  assign l2_req_op    = r_q_op[0];
  assign l2_req_addr  = r_q_addr[0];
  assign print_req    = r_print;
  assign busy         = r_state != IDLE;
`ifdef CACHE_STATS_EN
  logic w_look, w_cnt_clr;
  assign w_look    = r_state == LOOKUP && r_op <= OP_IFETCH;
  assign w_cnt_clr = w_accept && cmd.opcode == OP_CLEAR;
  cache_stats_counter u_hit (.clk, .rst, .i_clr(w_cnt_clr), .i_inc(w_look && dp_hit), .o_cnt(hit_cnt));
  cache_stats_counter u_miss (.clk, .rst, .i_clr(w_cnt_clr), .i_inc(w_look && !dp_hit), .o_cnt(miss_cnt));
  cache_stats_counter u_read (.clk, .rst, .i_clr(w_cnt_clr),
    .i_inc(r_state == LOOKUP && (r_op == OP_DREAD || r_op == OP_IFETCH)), .o_cnt(read_cnt));
  cache_stats_counter u_write (.clk, .rst, .i_clr(w_cnt_clr),
    .i_inc(r_state == LOOKUP && r_op == OP_DWRITE), .o_cnt(write_cnt));
`else
  assign hit_cnt   = '0;
  assign miss_cnt  = '0;
  assign read_cnt  = '0;
  assign write_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// tb_cache_cmd_sequencer: randomized command stream checked cycle by cycle against a bus-plan model
module tb_cache_cmd_sequencer;
  import my_struct_package::*;
  localparam int SB = 14, OB = 6, TW = 32 - SB - OB;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, rd_en, wr_en, clear_en;
  logic dp_hit, dp_victim_mod, dp_victim_shared, l2_req_valid, l2_req_ready, l2_done, print_req, busy;
  command_t cmd;
  logic [SB-1:0] set_index;
  logic [TW-1:0] dp_victim_tag;
  l2_op_t l2_req_op;
  logic [31:0] l2_req_addr, hit_cnt, miss_cnt, read_cnt, write_cnt;
  cache_cmd_sequencer #(.SET_BITS(SB), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .set_index(set_index), .rd_en(rd_en), .wr_en(wr_en), .clear_en(clear_en),
    .dp_hit(dp_hit), .dp_victim_mod(dp_victim_mod), .dp_victim_shared(dp_victim_shared),
    .dp_victim_tag(dp_victim_tag), .l2_req_valid(l2_req_valid), .l2_req_op(l2_req_op),
    .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready), .l2_done(l2_done),
    .print_req(print_req), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .read_cnt(read_cnt), .write_cnt(write_cnt));
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int m_hit = 0, m_miss = 0, m_read = 0, m_write = 0;
  typedef struct { int op; logic [31:0] addr; } bus_t;
  bus_t plan[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: bus ops 0=READ 1=WRITE 2=RFO 3=INVAL, derived from the command rules
  function automatic void model(input int op, input logic [31:0] a, input bit hit, input bit mod,
                                input bit sh, input logic [TW-1:0] vt);
    logic [31:0] line, wb;
    line = a - (a % (32'd1 << OB));
    wb = (32'(vt) << (SB + OB)) + (32'(a[OB +: SB]) << OB);
    plan.delete();
    if (op <= 2) begin
      if (hit) m_hit++; else m_miss++;
    end
    if (op == 0 || op == 2) m_read++;
    if (op == 1) m_write++;
    if (op <= 2 && !hit) begin
      if (mod) plan.push_back('{1, wb});
      plan.push_back('{(op == 1) ? 2 : 0, line});
    end else if (op == 1 && hit && sh) plan.push_back('{3, line});
    else if (op == 4 && hit && mod) plan.push_back('{1, wb});
  endfunction
  task automatic rand_dp();
    dp_hit = 1'($urandom);
    dp_victim_mod = 1'($urandom);
    dp_victim_shared = 1'($urandom);
    dp_victim_tag = TW'($urandom);
  endtask
  task automatic check_cnts(input string tag);
    check({tag, "_hit"}, hit_cnt, STATS ? 32'(m_hit) : 32'd0);
    check({tag, "_miss"}, miss_cnt, STATS ? 32'(m_miss) : 32'd0);
    check({tag, "_read"}, read_cnt, STATS ? 32'(m_read) : 32'd0);
    check({tag, "_write"}, write_cnt, STATS ? 32'(m_write) : 32'd0);
  endtask
  task automatic accept(input int op, input logic [31:0] a);
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd.opcode = 4'(op);
    cmd.addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd.opcode = 4'($urandom);
    cmd.addr = $urandom;
  endtask
  task automatic do_cmd(input int op, input logic [31:0] a, input bit hit, input bit mod, input bit sh,
                        input logic [TW-1:0] vt, input int rdly, input int ddly);
    int rd, dd;
    accept(op, a);
    if (op <= 4) begin
      check("rd_en", rd_en, 1);
      check("rd_set", set_index, a[OB +: SB]);
      check("busy", busy, 1);
      rand_dp();
      l2_done = 1'($urandom);
      @(negedge clk);
      check("lookup_quiet", {rd_en, wr_en, l2_req_valid}, 0);
      dp_hit = hit; dp_victim_mod = mod; dp_victim_shared = sh; dp_victim_tag = vt;
      l2_done = 1'($urandom);
      model(op, a, hit, mod, sh, vt);
      @(negedge clk);
      rand_dp();
      foreach (plan[i]) begin
        rd = rdly < 0 ? int'($urandom_range(0, 3)) : rdly;
        dd = ddly < 0 ? int'($urandom_range(0, 3)) : ddly;
        for (int k = 0; k <= rd; k++) begin
          check("req_valid", l2_req_valid, 1);
          check("req_op", l2_req_op, 64'(plan[i].op));
          check("req_addr", l2_req_addr, plan[i].addr);
          l2_req_ready = (k == rd);
          l2_done = 1'($urandom);
          @(negedge clk);
        end
        l2_req_ready = 1'b0;
        for (int k = 0; k <= dd; k++) begin
          check("wait_quiet", {l2_req_valid, wr_en}, 0);
          l2_done = (k == dd);
          @(negedge clk);
        end
        l2_done = 1'b0;
      end
      check("wr_en", {wr_en, clear_en, l2_req_valid}, 3'b100);
      check("wr_set", set_index, a[OB +: SB]);
      l2_done = 1'($urandom);
      @(negedge clk);
      l2_done = 1'b0;
      check("ready_after", {cmd_ready, busy}, 2'b10);
    end else begin
      check("noop_idle", {rd_en, busy, cmd_ready}, 3'b001);
      check("print_pulse", print_req, op == 9);
      @(negedge clk);
      check("print_end", print_req, 0);
    end
    check_cnts("cnt");
  endtask
  initial begin
    int ops[11] = '{0, 1, 2, 3, 4, 0, 1, 2, 9, 5, 7};
    int good;
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; l2_req_ready = 1'b0; l2_done = 1'b0;
    dp_hit = 1'b0; dp_victim_mod = 1'b0; dp_victim_shared = 1'b0; dp_victim_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", {cmd_ready, busy, rd_en, wr_en, clear_en, l2_req_valid, print_req}, 7'b1000000);
    check("rst_outs", {set_index, l2_req_op, l2_req_addr}, 0);
    check_cnts("rst");
    do_cmd(0, 32'h1234_5678, 1, 0, 0, '0, 0, 0);
    do_cmd(1, {12'h123, 14'd5, 6'h15}, 0, 1, 0, 12'hABC, 0, 1);
    do_cmd(1, 32'hCAFE_F00D, 1, 0, 1, 12'h111, 3, 2);
    do_cmd(4, 32'h0BAD_BEEF, 1, 1, 0, 12'h5A5, 1, 0);
    do_cmd(9, 32'h0, 0, 0, 0, '0, 0, 0);
    do_cmd(6, 32'h0, 0, 0, 0, '0, 0, 0);
    for (int n = 0; n < 80; n++)
      do_cmd(ops[$urandom_range(0, 10)], $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
             TW'($urandom), -1, -1);
    accept(8, $urandom);
    good = 0;
    for (int i = 0; i < (1 << SB); i++) begin
      if (wr_en && clear_en && !rd_en && set_index == SB'(i)) good++;
      l2_done = 1'($urandom);
      @(negedge clk);
    end
    l2_done = 1'b0;
    check("clear_cycles", good, 1 << SB);
    check("clear_done", {wr_en, clear_en, cmd_ready, busy}, 4'b0010);
    m_hit = 0; m_miss = 0; m_read = 0; m_write = 0;
    check_cnts("clr");
    do_cmd(2, 32'h7777_0040, 0, 0, 0, '0, 0, 0);
    accept(0, 32'h4444_1100);
    rand_dp();
    @(negedge clk);
    dp_hit = 1'b0; dp_victim_mod = 1'b0;
    @(negedge clk);
    check("rstt_req", l2_req_valid, 1);
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    check("rstt_wait", {l2_req_valid, busy}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_hit = 0; m_miss = 0; m_read = 0; m_write = 0;
    check("rstt_idle", {cmd_ready, busy, rd_en, wr_en, clear_en, l2_req_valid, print_req}, 7'b1000000);
    check("rstt_outs", {set_index, l2_req_op, l2_req_addr}, 0);
    check_cnts("rstt");
    l2_done = 1'b1;
    @(negedge clk);
    l2_done = 1'b0;
    check("late_done", {cmd_ready, busy, wr_en, l2_req_valid}, 4'b1000);
    @(negedge clk);
    check("late_done2", {cmd_ready, busy, wr_en, l2_req_valid}, 4'b1000);
    do_cmd(0, 32'h89AB_CDEF, 0, 1, 0, 12'h321, 2, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cache_cmd_sequencer.md
# cache_cmd_sequencer

Command-level controller for the split L1 cache (4-way instruction, 8-way data). It accepts one trace command at a time and reads the addressed set from line storage. It presents that set to the lookup/update datapath, then issues the required L2 bus operations over a valid/ready + done handshake and writes the updated set back. It sits between the trace reader and the cache storage/datapath, and it owns the clear sweep and the optional statistics counters.

## Interface
- SET_BITS, 14, set-index width; sets = 2**SET_BITS
- OFFSET_BITS, 6, byte offset width; line = 64 B
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command presented
- cmd_ready  out  1  sequencer can accept a command
- cmd  in  command_t  opcode n plus address (tag, set, offset)
- set_index  out  SET_BITS  set for storage read/write
- rd_en  out  1  storage read strobe; lines are valid one cycle later
- wr_en  out  1  storage write strobe for datapath return lines
- clear_en  out  1  with wr_en, write all ways invalid, LRU=0
- dp_hit  in  1  datapath hit in the selected cache
- dp_victim_mod  in  1  selected victim/hit line is MESI M
- dp_victim_shared  in  1  selected hit line is MESI S
- dp_victim_tag  in  tag width  tag of selected victim
- l2_req_valid  out  1  bus request
- l2_req_op  out  l2_op_t  READ/WRITE/RFO/INVAL
- l2_req_addr  out  32  line-aligned address
- l2_req_ready  in  1  bus accepts request
- l2_done  in  1  one-cycle completion pulse
- print_req  out  1  one-cycle pulse for opcode 9
- busy  out  1  not IDLE
- hit_cnt, miss_cnt, read_cnt, write_cnt  out  32 each  statistics

## Operation
- States: IDLE, READ_SET, LOOKUP, BUS_REQ, BUS_WAIT, WRITE_SET, CLEAR.
- cmd_ready = 1 only in IDLE with rst low. Accept = cmd_valid & cmd_ready. The command is registered on accept.
- Opcodes 0/1/2/3/4 follow IDLE→READ_SET (rd_en=1, set_index=cmd.set)→LOOKUP (sample dp_* signals).
- In LOOKUP, the bus plan is computed into an operation queue of at most 2 entries:
  - Op 0 or 2 miss: WRITE of victim if dp_victim_mod, then READ.
  - Op 1 miss: WRITE of victim if dp_victim_mod, then RFO.
  - Op 1 hit on S: INVAL.
  - Op 4 hit on M: WRITE.
  - Op 3, and all other hits: no bus operation.
- Queue empty → WRITE_SET. Otherwise → BUS_REQ.
- BUS_REQ: l2_req_valid=1 and op/addr held stable until l2_req_ready. Then → BUS_WAIT.
- BUS_WAIT: on l2_done, pop the queue; go to BUS_REQ if an entry remains, else WRITE_SET. l2_done in any other state is ignored.
- Address rules:
  - WRITE uses {dp_victim_tag, set, OFFSET_BITS'0}.
  - All other operations use cmd.address with the offset zeroed.
- WRITE_SET: wr_en=1 for one cycle → IDLE.
- Op 8: → CLEAR. clear_en=wr_en=1, set_index counts 0 up to 2**SET_BITS-1, one set per cycle. After the last set → IDLE. Counters are cleared.
- Op 9: print_req pulses in the cycle after accept; state stays IDLE.
- Other opcodes: consumed with no effect.
- Reset values: state IDLE, and every output 0 except cmd_ready=1. Reset mid-operation abandons the command: l2_req_valid drops the next cycle and any later l2_done is ignored.

## Timing
- A hit with no bus operation is accepted at T: rd_en at T+1, LOOKUP at T+2, wr_en at T+3, cmd_ready at T+4.
- Bus operations add (cycles in BUS_REQ) + (cycles until l2_done) each.
- l2_req_ready in the first BUS_REQ cycle is legal; the request lasts exactly one cycle.
- A clear takes 2**SET_BITS wr_en cycles plus the accept cycle.
- Counters update in the LOOKUP cycle and saturate at 32'hFFFF_FFFF:
  - hit/miss count ops 0–2.
  - read counts ops 0 and 2.
  - write counts op 1.

## Configuration
- CACHE_STATS_EN defined: the four counters are implemented as specified.
- CACHE_STATS_EN undefined: the counter logic is absent and all four count outputs are tied to 0. Sequencing is unchanged.

## Structure
- Add to my_struct_package:
  - seq_state_t enum.
  - l2_op_t enum: READ=0, WRITE=1, RFO=2, INVAL=3.
  - Opcode constants for 0–4, 8, 9.
- Sub-module cache_stats_counter: 32-bit saturating counter with clear. Four instances, generated only under CACHE_STATS_EN.

## Test plan
- Op 0, dp_hit=1 → no l2_req_valid, wr_en at T+3, cmd_ready at T+4, hit_cnt=1, read_cnt=1.
- Op 1 miss with dp_victim_mod=1, victim tag 12'hABC, set 5:
  - First request is WRITE at {12'hABC, 14'd5, 6'd0}.
  - After l2_done, second request is RFO at the line-aligned cmd address.
  - Then wr_en; miss_cnt=1, write_cnt=1.
- Op 1 hit with dp_victim_shared=1 → a single INVAL request; l2_req_ready held low for 3 cycles keeps valid/op/addr stable.
- Op 8 with SET_BITS=3 → exactly 8 wr_en/clear_en cycles, set_index 0..7, all counters reach 0.
- rst asserted in BUS_WAIT → next cycle IDLE with cmd_ready=1 and all outputs at reset values; a late l2_done causes no action.
- Op 9 → single print_req pulse, no rd_en, cmd_ready remains 1.
